dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/memory_pkg.sv | 5 +
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared data-memory geometry used by the memory-side blocks.
package memory_pkg;
  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_WORD_WIDTH = 32;
endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Every access walks IDLE -> ACCESS -> RESP, so only one access is in flight.
module dmem_arbiter #(
  parameter int ADDR_W = memory_pkg::MEM_ADDR_WIDTH,
  parameter int WORD_W = memory_pkg::MEM_WORD_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_unsigned,
  input  logic [1:0]        m0_nbytes,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [WORD_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic              m0_err,
  output logic [WORD_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_unsigned,
  input  logic [1:0]        m1_nbytes,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [WORD_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [WORD_W-1:0] m1_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              dmem_unsigned,
  output logic [1:0]        dmem_nbytes,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_addr_err,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic                win_s;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic [1:0]          nb_q, nb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          done_q, done_d;
  logic [WORD_W-1:0]   rdata0_q, rdata0_d;
  logic [WORD_W-1:0]   rdata1_q, rdata1_d;

  // Next-state, arbitration and command/response capture.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    win_s    = 1'b0;
    req_d    = 1'b0;
    we_d     = we_q;
    uns_d    = uns_q;
    nb_d     = nb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 2'b00;
    rdata0_d = '0;
    rdata1_d = '0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester that was not served last goes first.
          if (m0_req && m1_req) begin
            win_s = ~last_q;
          end else begin
            win_s = m1_req;
          end
          state_d = ACCESS;
          grant_d = win_s;
          last_d  = win_s;
          req_d   = 1'b1;
          if (win_s) begin
            we_d    = m1_we;
            uns_d   = m1_unsigned;
            nb_d    = m1_nbytes;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            we_d    = m0_we;
            uns_d   = m0_unsigned;
            nb_d    = m0_nbytes;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        done_d  = grant_q ? 2'b10 : 2'b01;
        // Memory read data is only valid during the request cycle, so grab it now.
        if (we_q) begin
          rdata0_d = '0;
          rdata1_d = '0;
        end else if (grant_q) begin
          rdata1_d = dmem_rdata;
        end else begin
          rdata0_d = dmem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      nb_q     <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      req_q    <= req_d;
      we_q     <= we_d;
      uns_q    <= uns_d;
      nb_q     <= nb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // The memory's error flag arrives registered in RESP, so it is gated by done here.
  assign m0_done       = done_q[0];
  assign m0_err        = done_q[0] & dmem_addr_err;
  assign m0_rdata      = rdata0_q;
  assign m1_done       = done_q[1];
  assign m1_err        = done_q[1] & dmem_addr_err;
  assign m1_rdata      = rdata1_q;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_unsigned = uns_q;
  assign dmem_nbytes   = nb_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level timeline model with its own memory image.
module tb_dmem_arbiter;
  localparam logic [15:0] BASE = 16'h1000;

  typedef struct {
    logic        we;
    logic        uns;
    logic [1:0]  nb;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          delay;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_s [2];
  logic        we_s [2];
  logic        uns_s [2];
  logic [1:0]  nb_s [2];
  logic [15:0] addr_s [2];
  logic [31:0] wdata_s [2];

  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dmem_req, dmem_we, dmem_unsigned, busy, grant_id;
  logic [1:0]  dmem_nbytes;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_addr_err = 1'b0;

  dmem_arbiter #(.ADDR_W(16), .WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req_s[0]), .m0_we(we_s[0]), .m0_unsigned(uns_s[0]), .m0_nbytes(nb_s[0]),
    .m0_addr(addr_s[0]), .m0_wdata(wdata_s[0]),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(req_s[1]), .m1_we(we_s[1]), .m1_unsigned(uns_s[1]), .m1_nbytes(nb_s[1]),
    .m1_addr(addr_s[1]), .m1_wdata(wdata_s[1]),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_unsigned(dmem_unsigned),
    .dmem_nbytes(dmem_nbytes), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_addr_err(dmem_addr_err),
    .busy(busy), .grant_id(grant_id)
  );

  // nbytes code: 0 -> 1 byte, 1 -> 2 bytes, 2/3 -> 4 bytes; loads extend to 32 bits.
  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [1:0] nb, input logic uns);
    case (nb)
      2'd0:    return uns ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic int nbytes_of(input logic [1:0] nb);
    return (nb == 2'd0) ? 1 : ((nb == 2'd1) ? 2 : 4);
  endfunction

  // Memory environment: combinational read, registered error, writes on the clock.
  logic [7:0]  mem [0:65535];
  bit          mem_clr = 1'b0;
  logic [31:0] env_raw;
  always_comb begin
    env_raw    = {mem[dmem_addr + 16'd3], mem[dmem_addr + 16'd2], mem[dmem_addr + 16'd1], mem[dmem_addr]};
    dmem_rdata = (dmem_req && dmem_addr >= BASE) ? ext(env_raw, dmem_nbytes, dmem_unsigned) : 32'h0;
  end
  always @(posedge clk) begin
    if (!mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      mem_clr <= 1'b1;
    end else if (dmem_req && dmem_we && dmem_addr >= BASE) begin
      mem[dmem_addr] <= dmem_wdata[7:0];
      if (dmem_nbytes != 2'd0) mem[dmem_addr + 16'd1] <= dmem_wdata[15:8];
      if (dmem_nbytes[1]) begin
        mem[dmem_addr + 16'd2] <= dmem_wdata[23:16];
        mem[dmem_addr + 16'd3] <= dmem_wdata[31:24];
      end
    end
    dmem_addr_err <= dmem_req && (dmem_addr < BASE);
  end

  // Reference model: timeline of grants (edge index) plus a private memory image.
  logic [7:0]  ref_mem [0:65535];
  int          e, g, free_at;
  bit          has_txn;
  logic        last_m, who_m;
  logic        t_we, t_uns;
  logic [1:0]  t_nb;
  logic [15:0] t_addr;
  logic [31:0] t_wdata, exp_rdata;
  logic        exp_err;

  int checks = 0;
  int errors = 0;
  int scn_cyc;
  bit rnd_on = 1'b0;
  op_t q0[$];
  op_t q1[$];
  int dly [2];
  int wait_cnt [2];
  int          log_who[$];
  int          log_cyc[$];
  logic [31:0] log_rd[$];
  logic        log_err[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0; g = -100; free_at = 0; has_txn = 1'b0;
    last_m = 1'b1; who_m = 1'b0;
    t_we = 1'b0; t_uns = 1'b0; t_nb = 2'd0; t_addr = 16'h0; t_wdata = 32'h0;
    exp_rdata = 32'h0; exp_err = 1'b0;
  endtask

  task automatic model_edge();
    logic w;
    int n;
    logic [31:0] raw;
    if (!rst_n) begin
      model_reset();
    end else begin
      e++;
      if (e >= free_at && (req_s[0] || req_s[1])) begin
        if (req_s[0] && req_s[1]) w = ~last_m;
        else w = req_s[1];
        last_m = w; who_m = w; has_txn = 1'b1; g = e; free_at = e + 3;
        t_we = we_s[w]; t_uns = uns_s[w]; t_nb = nb_s[w]; t_addr = addr_s[w]; t_wdata = wdata_s[w];
        exp_err = (t_addr < BASE);
        exp_rdata = 32'h0;
        n = nbytes_of(t_nb);
        if (t_we && !exp_err) begin
          for (int k = 0; k < n; k++) ref_mem[t_addr + 16'(k)] = t_wdata[8*k +: 8];
        end else if (!t_we && !exp_err) begin
          raw = {ref_mem[t_addr + 16'd3], ref_mem[t_addr + 16'd2], ref_mem[t_addr + 16'd1], ref_mem[t_addr]};
          exp_rdata = ext(raw, t_nb, t_uns);
        end
      end
    end
  endtask

  task automatic compare();
    logic in_acc, in_resp, d0, d1;
    in_acc  = has_txn && (e == g);
    in_resp = has_txn && (e == g + 1);
    d0 = in_resp && (who_m == 1'b0);
    d1 = in_resp && (who_m == 1'b1);
    chk("busy", {31'h0, busy}, {31'h0, in_acc | in_resp});
    chk("grant_id", {31'h0, grant_id}, {31'h0, who_m});
    chk("dmem_req", {31'h0, dmem_req}, {31'h0, in_acc});
    chk("dmem_we", {31'h0, dmem_we}, {31'h0, t_we});
    chk("dmem_unsigned", {31'h0, dmem_unsigned}, {31'h0, t_uns});
    chk("dmem_nbytes", {30'h0, dmem_nbytes}, {30'h0, t_nb});
    chk("dmem_addr", {16'h0, dmem_addr}, {16'h0, t_addr});
    chk("dmem_wdata", dmem_wdata, t_wdata);
    chk("m0_done", {31'h0, m0_done}, {31'h0, d0});
    chk("m0_err", {31'h0, m0_err}, {31'h0, d0 & exp_err});
    chk("m0_rdata", m0_rdata, d0 ? exp_rdata : 32'h0);
    chk("m1_done", {31'h0, m1_done}, {31'h0, d1});
    chk("m1_err", {31'h0, m1_err}, {31'h0, d1 & exp_err});
    chk("m1_rdata", m1_rdata, d1 ? exp_rdata : 32'h0);
  endtask

  function automatic int qsize(input int r);
    return (r == 1) ? q1.size() : q0.size();
  endfunction

  function automatic op_t qhead(input int r);
    return (r == 1) ? q1[0] : q0[0];
  endfunction

  task automatic qpop(input int r);
    if (r == 1) void'(q1.pop_front());
    else void'(q0.pop_front());
  endtask

  task automatic qpush(input int r, input logic we, input logic uns, input logic [1:0] nb,
                       input logic [15:0] addr, input logic [31:0] wdata, input int delay);
    op_t op;
    op.we = we; op.uns = uns; op.nb = nb; op.addr = addr; op.wdata = wdata; op.delay = delay;
    if (r == 1) q1.push_back(op);
    else q0.push_back(op);
  endtask

  task automatic apply(input int r);
    op_t op;
    op = qhead(r);
    req_s[r] = 1'b1; we_s[r] = op.we; uns_s[r] = op.uns; nb_s[r] = op.nb;
    addr_s[r] = op.addr; wdata_s[r] = op.wdata;
  endtask

  task automatic drive();
    logic dn;
    for (int r = 0; r < 2; r++) begin
      dn = (r == 1) ? m1_done : m0_done;
      if (req_s[r]) begin
        if (dn) begin
          qpop(r);
          wait_cnt[r] = 0; dly[r] = 0;
          if (qsize(r) > 0 && qhead(r).delay == 0) apply(r);
          else req_s[r] = 1'b0;
        end else begin
          wait_cnt[r]++;
          if (wait_cnt[r] > 12) begin
            checks++; errors++;
            $display("FAIL done_timeout: requester %0d waited %0d cycles, required at most 12", r, wait_cnt[r]);
            req_s[r] = 1'b0; qpop(r); wait_cnt[r] = 0;
          end
        end
      end else if (qsize(r) > 0) begin
        if (dly[r] < qhead(r).delay) dly[r]++;
        else begin
          apply(r); dly[r] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    scn_cyc++;
    compare();
    if (m0_done === 1'b1) begin
      log_who.push_back(0); log_cyc.push_back(scn_cyc); log_rd.push_back(m0_rdata); log_err.push_back(m0_err);
    end
    if (m1_done === 1'b1) begin
      log_who.push_back(1); log_cyc.push_back(scn_cyc); log_rd.push_back(m1_rdata); log_err.push_back(m1_err);
    end
    if (rnd_on) begin
      for (int r = 0; r < 2; r++) begin
        if (qsize(r) < 2 && $urandom_range(0, 2) == 0) begin
          qpush(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 16'h0FFF)) : BASE + 16'($urandom_range(0, 63)),
                $urandom, $urandom_range(0, 2));
        end
      end
    end
    drive();
  endtask

  function automatic bit all_idle();
    return q0.size() == 0 && q1.size() == 0 && !req_s[0] && !req_s[1] && (!has_txn || e >= g + 2);
  endfunction

  task automatic run_idle(input int max);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!all_idle() && n < max);
    if (!all_idle()) begin
      checks++; errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic begin_scn();
    scn_cyc = 0;
    log_who.delete(); log_cyc.delete(); log_rd.delete(); log_err.delete();
  endtask

  task automatic clear_drivers();
    q0.delete(); q1.delete();
    for (int r = 0; r < 2; r++) begin
      req_s[r] = 1'b0; dly[r] = 0; wait_cnt[r] = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      req_s[r] = 1'b0; we_s[r] = 1'b0; uns_s[r] = 1'b0; nb_s[r] = 2'd0;
      addr_s[r] = 16'h0; wdata_s[r] = 32'h0; dly[r] = 0; wait_cnt[r] = 0;
    end
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    model_reset();
    scn_cyc = 0;
    cycle();
    cycle();
    rst_n = 1'b1;
    run_idle(10);

    // Simultaneous held requests alternate starting with requester 0.
    begin_scn();
    qpush(0, 1'b0, 1'b0, 2'd2, 16'h1000, 32'h0, 0);
    qpush(0, 1'b0, 1'b0, 2'd2, 16'h1004, 32'h0, 0);
    qpush(1, 1'b0, 1'b0, 2'd2, 16'h1008, 32'h0, 0);
    qpush(1, 1'b0, 1'b0, 2'd2, 16'h100C, 32'h0, 0);
    run_idle(60);
    chk("rr_count", 32'(log_who.size()), 32'd4);
    chk("rr_who0", 32'(log_who[0]), 32'd0);
    chk("rr_who1", 32'(log_who[1]), 32'd1);
    chk("rr_who2", 32'(log_who[2]), 32'd0);
    chk("rr_who3", 32'(log_who[3]), 32'd1);
    chk("rr_cyc0", 32'(log_cyc[0]), 32'd3);
    chk("rr_cyc3", 32'(log_cyc[3]), 32'd12);

    // Word store then word load of the same address.
    begin_scn();
    qpush(0, 1'b1, 1'b0, 2'd2, 16'h4000, 32'hDEADBEEF, 0);
    qpush(0, 1'b0, 1'b0, 2'd2, 16'h4000, 32'h0, 0);
    run_idle(30);
    chk("st_cyc", 32'(log_cyc[0]), 32'd3);
    chk("ld_cyc", 32'(log_cyc[1]), 32'd6);
    chk("ld_rdata", log_rd[1], 32'hDEADBEEF);
    chk("ld_err", {31'h0, log_err[1]}, 32'd0);

    // Load below the data memory window.
    begin_scn();
    qpush(1, 1'b0, 1'b0, 2'd2, 16'h0000, 32'h0, 0);
    run_idle(20);
    chk("err_who", 32'(log_who[0]), 32'd1);
    chk("err_flag", {31'h0, log_err[0]}, 32'd1);
    chk("err_rdata", log_rd[0], 32'h0);

    // Signed and unsigned byte loads of 0x80.
    begin_scn();
    qpush(0, 1'b1, 1'b0, 2'd0, 16'h4010, 32'h12345680, 0);
    qpush(0, 1'b0, 1'b0, 2'd0, 16'h4010, 32'h0, 0);
    qpush(0, 1'b0, 1'b1, 2'd0, 16'h4010, 32'h0, 0);
    run_idle(40);
    chk("lb_signed", log_rd[1], 32'hFFFFFF80);
    chk("lb_unsigned", log_rd[2], 32'h00000080);

    // Requester 1 arrives while requester 0 is in its response cycle.
    begin_scn();
    qpush(0, 1'b0, 1'b0, 2'd2, 16'h4010, 32'h0, 0);
    qpush(1, 1'b0, 1'b0, 2'd2, 16'h4000, 32'h0, 2);
    run_idle(30);
    chk("late_m0_cyc", 32'(log_cyc[0]), 32'd3);
    chk("late_m1_who", 32'(log_who[1]), 32'd1);
    chk("late_m1_cyc", 32'(log_cyc[1]), 32'd6);
    chk("late_m1_rdata", log_rd[1], 32'hDEADBEEF);

    // Reset pulsed during ACCESS aborts the access and restores the tie-break.
    begin_scn();
    qpush(0, 1'b0, 1'b0, 2'd2, 16'h4000, 32'h0, 0);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'd0);
    chk("rst_m0_done", {31'h0, m0_done}, 32'd0);
    clear_drivers();
    model_reset();
    cycle();
    rst_n = 1'b1;
    run_idle(10);
    chk("rst_no_done", 32'(log_who.size()), 32'd0);
    begin_scn();
    qpush(0, 1'b0, 1'b0, 2'd2, 16'h1000, 32'h0, 0);
    qpush(1, 1'b0, 1'b0, 2'd2, 16'h1004, 32'h0, 0);
    run_idle(30);
    chk("rst_first_who", 32'(log_who[0]), 32'd0);
    chk("rst_second_who", 32'(log_who[1]), 32'd1);

    // Random traffic from both requesters.
    begin_scn();
    rnd_on = 1'b1;
    repeat (600) cycle();
    rnd_on = 1'b0;
    run_idle(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
